// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: default depth, FSM states and
// port-select encoding.
package dmem_pkg;

  localparam int unsigned DEPTH_DEFAULT = 10;

  typedef enum logic {StIdle, StAccess} state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a sole requester always wins, a tie goes to the port
// that did not win last time.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req_a & (~req_b | (last_grant == SEL_B));
    gnt[1] = req_b & (~req_a | (last_grant == SEL_A));
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares a single-port data memory between requesters A and B: round-robin grant,
// one access cycle, registered response, out-of-range addresses trapped.
module data_mem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic          a_err,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          b_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_e        state_q;
  logic          last_q;
  logic          sel_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          a_rvalid_q, b_rvalid_q, a_err_q, b_err_q;
  logic [DW-1:0] a_rdata_q, b_rdata_q;

  logic          idle;
  logic          in_range;
  logic          access;
  logic [1:0]    arb_gnt;
  logic [DW-1:0] rsp_data;

  assign idle   = (state_q == StIdle);
  assign access = (state_q == StAccess);

  // Requests are masked in ACCESS so no grant can ever be issued there.
  rr_arb2 u_rr_arb2 (
    .req_a      (a_req & idle),
    .req_b      (b_req & idle),
    .last_grant (last_q),
    .gnt        (arb_gnt)
  );

  assign a_gnt = arb_gnt[0];
  assign b_gnt = arb_gnt[1];

  assign in_range = (addr_q < AW'(DEPTH));

  // Memory side is driven only during ACCESS; an async reset drops mem_we at once.
  assign mem_we    = access & we_q & in_range;
  assign mem_addr  = access ? addr_q  : '0;
  assign mem_wdata = access ? wdata_q : '0;
  assign rsp_data  = (in_range && !we_q) ? mem_rdata : '0;

  assign a_rvalid = a_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign a_err    = a_err_q;
  assign b_rvalid = b_rvalid_q;
  assign b_rdata  = b_rdata_q;
  assign b_err    = b_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      last_q     <= SEL_B;
      sel_q      <= SEL_A;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      a_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      a_err_q    <= 1'b0;
      b_rvalid_q <= 1'b0;
      b_rdata_q  <= '0;
      b_err_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          a_rvalid_q <= 1'b0;
          b_rvalid_q <= 1'b0;
          if (arb_gnt[0]) begin
            state_q <= StAccess;
            sel_q   <= SEL_A;
            last_q  <= SEL_A;
            we_q    <= a_we;
            addr_q  <= a_addr;
            wdata_q <= a_wdata;
          end else if (arb_gnt[1]) begin
            state_q <= StAccess;
            sel_q   <= SEL_B;
            last_q  <= SEL_B;
            we_q    <= b_we;
            addr_q  <= b_addr;
            wdata_q <= b_wdata;
          end
        end
        StAccess: begin
          state_q <= StIdle;
          if (sel_q == SEL_A) begin
            a_rvalid_q <= 1'b1;
            a_rdata_q  <= rsp_data;
            a_err_q    <= ~in_range;
          end else begin
            b_rvalid_q <= 1'b1;
            b_rdata_q  <= rsp_data;
            b_err_q    <= ~in_range;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 10-word memory attached.
module tb_data_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_req, a_we, a_gnt, a_rvalid, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_req, b_we, b_gnt, b_rvalid, b_err;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:9];

  int n_cmp;
  int n_err;

  data_mem_arbiter #(
    .DEPTH (10),
    .AW    (32),
    .DW    (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_gnt     (a_gnt),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .a_err     (a_err),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_gnt     (b_gnt),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata),
    .b_err     (b_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 10; i++) mem[i] = 32'h0;
  end

  always @(posedge clk) begin
    if (mem_we && mem_addr < 32'd10) mem[mem_addr[3:0]] <= mem_wdata;
  end

  assign mem_rdata = (mem_addr < 32'd10) ? mem[mem_addr[3:0]] : 32'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    drive_b(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_a_rvalid", {31'h0, a_rvalid}, 32'h0);
    chk("rst_b_rvalid", {31'h0, b_rvalid}, 32'h0);
    chk("rst_a_rdata", a_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    rst_n = 1'b1;
    tick();

    // A writes 0xDEADBEEF to addr 3
    drive_a(1'b1, 1'b1, 32'd3, 32'hDEADBEEF);
    #1;
    chk("t1_a_gnt", {31'h0, a_gnt}, 32'h1);
    chk("t1_b_gnt", {31'h0, b_gnt}, 32'h0);
    chk("t1_idle_mem_we", {31'h0, mem_we}, 32'h0);
    tick();
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("t1_acc_mem_we", {31'h0, mem_we}, 32'h1);
    chk("t1_acc_mem_addr", mem_addr, 32'd3);
    chk("t1_acc_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("t1_acc_a_rvalid", {31'h0, a_rvalid}, 32'h0);
    tick();
    chk("t1_w_a_rvalid", {31'h0, a_rvalid}, 32'h1);
    chk("t1_w_a_err", {31'h0, a_err}, 32'h0);
    chk("t1_w_a_rdata", a_rdata, 32'h0);
    chk("t1_w_b_rvalid", {31'h0, b_rvalid}, 32'h0);
    // New grant coincides with the response cycle
    drive_a(1'b1, 1'b0, 32'd3, 32'h0);
    #1;
    chk("t6_a_gnt_with_rvalid", {31'h0, a_gnt}, 32'h1);
    tick();
    #1;
    chk("t6_no_gnt_in_access", {31'h0, a_gnt}, 32'h0);
    chk("t1_r_mem_we", {31'h0, mem_we}, 32'h0);
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("t1_r_a_rvalid", {31'h0, a_rvalid}, 32'h1);
    chk("t1_r_a_rdata", a_rdata, 32'hDEADBEEF);
    tick();
    chk("t1_rvalid_pulse", {31'h0, a_rvalid}, 32'h0);
    chk("t1_rdata_hold", a_rdata, 32'hDEADBEEF);

    // B writes 0x12345678 to addr 5, then A reads it back
    drive_b(1'b1, 1'b1, 32'd5, 32'h12345678);
    #1;
    chk("t4_b_gnt", {31'h0, b_gnt}, 32'h1);
    tick();
    drive_b(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("t4_b_rvalid", {31'h0, b_rvalid}, 32'h1);
    chk("t4_b_err", {31'h0, b_err}, 32'h0);
    chk("t4_a_rvalid_quiet", {31'h0, a_rvalid}, 32'h0);
    drive_a(1'b1, 1'b0, 32'd5, 32'h0);
    #1;
    chk("t4_a_gnt", {31'h0, a_gnt}, 32'h1);
    tick();
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("t4_a_rdata", a_rdata, 32'h12345678);

    // Out-of-range writes from B: addr 10 and addr 0xFFFFFFFF
    drive_b(1'b1, 1'b1, 32'd10, 32'hAAAA5555);
    #1;
    chk("t3_b_gnt_10", {31'h0, b_gnt}, 32'h1);
    tick();
    drive_b(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("t3_mem_we_10", {31'h0, mem_we}, 32'h0);
    chk("t3_mem_addr_10", mem_addr, 32'd10);
    tick();
    chk("t3_b_rvalid_10", {31'h0, b_rvalid}, 32'h1);
    chk("t3_b_err_10", {31'h0, b_err}, 32'h1);
    chk("t3_b_rdata_10", b_rdata, 32'h0);
    chk("t3_a_rdata_hold", a_rdata, 32'h12345678);
    drive_b(1'b1, 1'b1, 32'hFFFFFFFF, 32'h5555AAAA);
    tick();
    drive_b(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("t3_mem_we_max", {31'h0, mem_we}, 32'h0);
    tick();
    chk("t3_b_err_max", {31'h0, b_err}, 32'h1);
    chk("t3_b_rdata_max", b_rdata, 32'h0);
    drive_b(1'b1, 1'b1, 32'd9, 32'h00000099);
    tick();
    drive_b(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("t3_mem_we_9", {31'h0, mem_we}, 32'h1);
    tick();
    chk("t3_b_err_9", {31'h0, b_err}, 32'h0);
    chk("t3_mem9", mem[9], 32'h00000099);

    // Fresh reset, then both ports request continuously: A,B,A,B
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    drive_a(1'b1, 1'b0, 32'd3, 32'h0);
    drive_b(1'b1, 1'b0, 32'd5, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t2_a_gnt_%0d", i), {31'h0, a_gnt}, (i % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("t2_b_gnt_%0d", i), {31'h0, b_gnt}, (i % 2 == 1) ? 32'h1 : 32'h0);
      tick();
      chk($sformatf("t2_acc_gnt_%0d", i), {30'h0, a_gnt, b_gnt}, 32'h0);
      tick();
      chk($sformatf("t2_a_rvalid_%0d", i), {31'h0, a_rvalid}, (i % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("t2_b_rvalid_%0d", i), {31'h0, b_rvalid}, (i % 2 == 1) ? 32'h1 : 32'h0);
    end
    chk("t2_a_rdata", a_rdata, 32'hDEADBEEF);
    chk("t2_b_rdata", b_rdata, 32'h12345678);
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    drive_b(1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Reset asserted during the ACCESS cycle of a write to addr 2
    drive_a(1'b1, 1'b1, 32'd2, 32'h00000BAD);
    #1;
    chk("t5_a_gnt", {31'h0, a_gnt}, 32'h1);
    tick();
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("t5_mem_we_before", {31'h0, mem_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t5_mem_we_async", {31'h0, mem_we}, 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("t5_a_rvalid", {31'h0, a_rvalid}, 32'h0);
    chk("t5_mem2", mem[2], 32'h0);
    drive_a(1'b1, 1'b0, 32'd2, 32'h0);
    #1;
    chk("t5_next_gnt", {31'h0, a_gnt}, 32'h1);
    tick();
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("t5_next_rvalid", {31'h0, a_rvalid}, 32'h1);
    chk("t5_next_rdata", a_rdata, 32'h0);
    chk("t5_next_err", {31'h0, a_err}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
